// File: rtl/uart2apb_pkg.sv
// Shared types and constants for the uart2apb bridge frame controller.
package uart2apb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    SETUP,
    ACCESS,
    RESP
  } state_e;

  localparam logic [7:0] CMD_WR    = 8'h57;
  localparam logic [7:0] CMD_RD    = 8'h52;
  localparam logic [7:0] ST_OK     = 8'h00;
  localparam logic [7:0] ST_SLVERR = 8'h01;

endpackage

// File: rtl/uart2apb_timeout_cnt.sv
// Inter-byte idle counter: o_hit flags the cycle in which the count reaches TIMEOUT_CYC.
module uart2apb_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter int unsigned TO_W        = 17
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_hit
);

  logic [TO_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + TO_W'(1);
    end
  end

  // Fires on the increment that would take the count to TIMEOUT_CYC.
  assign o_hit = i_inc && !i_clr && (r_cnt == TO_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/uart2apb_frame_ctrl.sv
// Frame sequencer: RX FIFO command frames -> one APB transfer -> TX FIFO response.
// Optional inter-byte timeout enabled by defining UART2APB_FRAME_TIMEOUT_EN.
module uart2apb_frame_ctrl
  import uart2apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter int unsigned TO_W        = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_empty,
  input  logic [7:0]  rx_rd_data,
  output logic        rx_rd_en,
  input  logic        tx_full,
  output logic        tx_wr_en,
  output logic [7:0]  tx_wr_data,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  output logic        pwrite,
  output logic        psel,
  output logic        penable,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr,
  output logic        busy,
  output logic        frame_err,
  output logic        timeout_err
);

  if ((64'd1 << TO_W) <= 64'(TIMEOUT_CYC)) begin : g_bad_to_w
    $error("TO_W too narrow for TIMEOUT_CYC");
  end

  state_e      r_state;
  state_e      w_next;
  logic [1:0]  r_byte_cnt;
  logic [2:0]  r_tx_idx;
  logic        r_is_wr;
  logic        r_slverr;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        w_pop;
  logic        w_push;
  logic        w_cmd_ok;
  logic        w_to_hit;
  logic [2:0]  w_last_idx;

`ifdef UART2APB_FRAME_TIMEOUT_EN
  logic w_in_frame;
  assign w_in_frame = (r_state == ADDR) || (r_state == WDATA);

  uart2apb_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TO_W        (TO_W)
  ) u_timeout_cnt (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_clr   (w_pop),
    .i_inc   (w_in_frame && rx_empty),
    .o_hit   (w_to_hit)
  );
  assign timeout_err = w_to_hit;
`else
  assign w_to_hit    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign w_cmd_ok   = (rx_rd_data == CMD_WR) || (rx_rd_data == CMD_RD);
  assign w_last_idx = r_is_wr ? 3'd0 : 3'd4;
  assign w_pop      = rx_rd_en;
  assign w_push     = tx_wr_en;
  assign busy       = (r_state != IDLE);
  assign paddr      = r_addr;
  assign pwdata     = r_wdata;
  assign pwrite     = r_is_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    rx_rd_en  = 1'b0;
    tx_wr_en  = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    frame_err = 1'b0;
    case (r_state)
      IDLE: begin
        rx_rd_en = ~rx_empty;
        if (!rx_empty) begin
          if (w_cmd_ok) w_next = ADDR;
          else          frame_err = 1'b1;
        end
      end
      ADDR: begin
        rx_rd_en = ~rx_empty;
        if (w_to_hit) begin
          w_next = IDLE;
        end else if (!rx_empty && r_byte_cnt == 2'd3) begin
          w_next = r_is_wr ? WDATA : SETUP;
        end
      end
      WDATA: begin
        rx_rd_en = ~rx_empty;
        if (w_to_hit) begin
          w_next = IDLE;
        end else if (!rx_empty && r_byte_cnt == 2'd3) begin
          w_next = SETUP;
        end
      end
      SETUP: begin
        psel   = 1'b1;
        w_next = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready) w_next = RESP;
      end
      RESP: begin
        tx_wr_en = ~tx_full;
        if (!tx_full && r_tx_idx == w_last_idx) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    tx_wr_data = '0;
    if (r_state == RESP) begin
      case (r_tx_idx)
        3'd0:    tx_wr_data = r_slverr ? ST_SLVERR : ST_OK;
        3'd1:    tx_wr_data = r_rdata[31:24];
        3'd2:    tx_wr_data = r_rdata[23:16];
        3'd3:    tx_wr_data = r_rdata[15:8];
        3'd4:    tx_wr_data = r_rdata[7:0];
        default: tx_wr_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_cnt <= '0;
      r_tx_idx   <= '0;
      r_is_wr    <= 1'b0;
      r_slverr   <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop && w_cmd_ok) begin
            r_is_wr    <= (rx_rd_data == CMD_WR);
            r_byte_cnt <= '0;
          end
        end
        ADDR: begin
          if (w_pop) begin
            r_addr     <= {r_addr[23:0], rx_rd_data};
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
        end
        WDATA: begin
          if (w_pop) begin
            r_wdata    <= {r_wdata[23:0], rx_rd_data};
            r_byte_cnt <= r_byte_cnt + 2'd1;
          end
        end
        ACCESS: begin
          if (pready) begin
            r_rdata  <= prdata;
            r_slverr <= pslverr;
            r_tx_idx <= '0;
          end
        end
        RESP: begin
          if (w_push) r_tx_idx <= r_tx_idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart2apb_frame_ctrl.sv
// Self-checking bench for uart2apb_frame_ctrl: frame-level reference model with randomized traffic.
module tb_uart2apb_frame_ctrl;

  localparam int K_MID = 0, K_LAST = 1, K_ILL = 2, K_CMD = 3;

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_empty;
  logic [7:0]  rx_rd_data;
  logic        rx_rd_en;
  logic        tx_full;
  logic        tx_wr_en;
  logic [7:0]  tx_wr_data;
  logic [31:0] paddr, pwdata, prdata;
  logic        pwrite, psel, penable, pready, pslverr;
  logic        busy, frame_err, timeout_err;

  always #5 clk = ~clk;

`ifdef UART2APB_FRAME_TIMEOUT_EN
  uart2apb_frame_ctrl #(.TIMEOUT_CYC(16), .TO_W(5)) dut (
`else
  uart2apb_frame_ctrl dut (
`endif
    .clk(clk), .rst_n(rst_n), .rx_empty(rx_empty), .rx_rd_data(rx_rd_data),
    .rx_rd_en(rx_rd_en), .tx_full(tx_full), .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data),
    .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .pslverr(pslverr), .busy(busy),
    .frame_err(frame_err), .timeout_err(timeout_err)
  );

  // Model state
  logic [7:0]  rxq[$];
  int          rxk[$];
  txn_t        exp_txn[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  got_tx[$];
  bit          mid_frame, apb_pending, apb_first;
  int          resp_pending;
  int          wait_cnt, wait_target;
  logic [31:0] cur_rd;
  bit          cur_err;
  // Stimulus knobs
  int          stall_pct, txf_mode, fix_wait, fix_err;
  bit          fix_rd_en;
  logic [31:0] fix_rd;
  // Observations
  int          cyc, last_pop_cyc, pen_cnt, fe_cnt, to_pulses, to_cyc;
  logic [31:0] last_a, last_d;
  bit          last_w;
  int          n_checks, n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic add_frame(input bit wr, input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    rxq.push_back(wr ? 8'h57 : 8'h52); rxk.push_back(K_CMD);
    for (int i = 3; i >= 0; i--) begin
      rxq.push_back(a[8*i +: 8]);
      rxk.push_back((!wr && i == 0) ? K_LAST : K_MID);
    end
    if (wr) begin
      for (int i = 3; i >= 0; i--) begin
        rxq.push_back(d[8*i +: 8]);
        rxk.push_back(i == 0 ? K_LAST : K_MID);
      end
    end
    t.wr = wr; t.a = a; t.d = d;
    exp_txn.push_back(t);
  endtask

  task automatic add_illegal(input logic [7:0] b);
    logic [7:0] v;
    v = b;
    if (v == 8'h57 || v == 8'h52) v = 8'hA5;
    rxq.push_back(v); rxk.push_back(K_ILL);
  endtask

  task automatic cycle();
    bit pop, push, acc, first, wr;
    int k;
    @(negedge clk);
    cyc++;
    rx_empty   = (rxq.size() == 0) || ($urandom_range(0, 99) < stall_pct);
    rx_rd_data = rx_empty ? 8'($urandom) : rxq[0];
    case (txf_mode)
      0:       tx_full = 1'b0;
      1:       tx_full = ~tx_full;
      default: tx_full = 1'($urandom_range(0, 1));
    endcase
    first = apb_pending && apb_first;
    acc   = apb_pending && !apb_first;
    if (first) begin
      wait_cnt    = 0;
      wait_target = (fix_wait < 0) ? int'($urandom_range(0, 3)) : fix_wait;
      cur_rd      = fix_rd_en ? fix_rd : $urandom;
      cur_err     = (fix_err < 0) ? 1'($urandom_range(0, 1)) : fix_err[0];
    end
    pready  = acc ? (wait_cnt >= wait_target) : 1'($urandom_range(0, 1));
    prdata  = acc ? cur_rd : $urandom;
    pslverr = acc ? cur_err : 1'($urandom_range(0, 1));
    #1;
    pop  = !rx_empty && !apb_pending && resp_pending == 0;
    push = resp_pending > 0 && !tx_full;
    k    = pop ? rxk[0] : K_MID;
    chk("rx_rd_en", rx_rd_en, pop);
    chk("frame_err", frame_err, pop && k == K_ILL);
    chk("psel", psel, apb_pending);
    chk("penable", penable, acc);
    chk("busy", busy, mid_frame || apb_pending || resp_pending > 0);
    chk("tx_wr_en", tx_wr_en, push);
    if (penable) pen_cnt++;
    if (frame_err) fe_cnt++;
    if (tx_wr_en && !tx_full) got_tx.push_back(tx_wr_data);
    if (apb_pending) begin
      chk("txn_expected", exp_txn.size() > 0, 1);
      if (exp_txn.size() > 0) begin
        chk("paddr", paddr, exp_txn[0].a);
        chk("pwrite", pwrite, exp_txn[0].wr);
        if (exp_txn[0].wr) chk("pwdata", pwdata, exp_txn[0].d);
      end
    end
    if (push) begin
      chk("tx_byte_expected", exp_tx.size() > 0, 1);
      if (exp_tx.size() > 0) begin
        chk("tx_wr_data", tx_wr_data, exp_tx[0]);
        exp_tx.delete(0);
      end
      resp_pending--;
    end
`ifdef UART2APB_FRAME_TIMEOUT_EN
    if (timeout_err) begin to_pulses++; to_cyc = cyc; mid_frame = 0; end
`else
    chk("timeout_err", timeout_err, 1'b0);
`endif
    if (pop) begin
      rxq.delete(0); rxk.delete(0);
      last_pop_cyc = cyc;
      if (k == K_CMD) mid_frame = 1;
      else if (k == K_LAST) begin
        mid_frame = 0; apb_pending = 1; apb_first = 1;
      end
    end
    if (acc) begin
      if (pready) begin
        last_a = paddr; last_d = pwdata; last_w = pwrite;
        wr = (exp_txn.size() > 0) ? exp_txn[0].wr : 1'b1;
        if (exp_txn.size() > 0) exp_txn.delete(0);
        exp_tx.push_back(cur_err ? 8'h01 : 8'h00);
        if (!wr) for (int i = 3; i >= 0; i--) exp_tx.push_back(cur_rd[8*i +: 8]);
        resp_pending = wr ? 1 : 5;
        apb_pending  = 0;
      end else begin
        wait_cnt++;
      end
    end
    if (first) apb_first = 0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (!(rxq.size() == 0 && !apb_pending && resp_pending == 0 && !mid_frame) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_within_budget", n < budget, 1);
    cycle();
  endtask

  initial begin
    int base, fe0;
    rst_n = 1'b0; rx_empty = 1'b1; rx_rd_data = '0; tx_full = 1'b0;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    stall_pct = 0; txf_mode = 0; fix_wait = 0; fix_err = 0; fix_rd_en = 0; fix_rd = '0;
    #12;
    chk("reset_apb", {paddr, pwdata}, 64'h0);
    chk("reset_ctl", {pwrite, psel, penable, tx_wr_en, tx_wr_data, rx_rd_en, busy, frame_err, timeout_err},
        16'h0);
    @(negedge clk); rst_n = 1'b1;

    // Directed write
    add_frame(1'b1, 32'h0000_1004, 32'hDEAD_BEEF);
    base = got_tx.size();
    drain(200);
    chk("wr_paddr", last_a, 32'h0000_1004);
    chk("wr_pwdata", last_d, 32'hDEAD_BEEF);
    chk("wr_pwrite", last_w, 1'b1);
    chk("wr_tx_count", got_tx.size() - base, 1);
    if (got_tx.size() > base) chk("wr_status", got_tx[base], 8'h00);

    // Read with 3 wait states
    fix_wait = 3; fix_rd_en = 1; fix_rd = 32'h1234_5678; pen_cnt = 0;
    add_frame(1'b0, 32'h0000_2000, 32'h0);
    base = got_tx.size();
    drain(200);
    chk("rd_penable_cycles", pen_cnt, 4);
    chk("rd_tx_count", got_tx.size() - base, 5);
    if (got_tx.size() >= base + 5)
      chk("rd_tx_bytes", {got_tx[base], got_tx[base+1], got_tx[base+2], got_tx[base+3], got_tx[base+4]},
          40'h00_12_34_56_78);

    // Slave error with TX backpressure toggling
    fix_wait = 0; fix_err = 1; fix_rd = 32'hCAFE_F00D; txf_mode = 1;
    add_frame(1'b0, 32'h0000_3000, 32'h0);
    base = got_tx.size();
    drain(200);
    chk("err_tx_count", got_tx.size() - base, 5);
    if (got_tx.size() >= base + 5)
      chk("err_tx_bytes", {got_tx[base], got_tx[base+1], got_tx[base+2], got_tx[base+3], got_tx[base+4]},
          40'h01_CA_FE_F0_0D);

    // Illegal byte then a valid read
    txf_mode = 0; fix_err = 0; fix_rd = 32'h0BAD_F00D;
    fe0 = fe_cnt;
    add_illegal(8'hA5);
    add_frame(1'b0, 32'h0000_4000, 32'h0);
    base = got_tx.size();
    drain(200);
    chk("illegal_frame_err_pulses", fe_cnt - fe0, 1);
    chk("illegal_then_read_tx_count", got_tx.size() - base, 5);

`ifdef UART2APB_FRAME_TIMEOUT_EN
    to_pulses = 0;
    rxq.push_back(8'h57); rxk.push_back(K_CMD);
    rxq.push_back(8'h00); rxk.push_back(K_MID);
    for (int i = 0; i < 40; i++) cycle();
    chk("timeout_pulses", to_pulses, 1);
    chk("timeout_latency", to_cyc - last_pop_cyc, 16);
    add_frame(1'b0, 32'h0000_5000, 32'h0);
    drain(200);
`endif

    // Randomized traffic
    fix_wait = -1; fix_err = -1; fix_rd_en = 0; stall_pct = 30; txf_mode = 2;
    for (int f = 0; f < 60; f++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0)     add_illegal(8'($urandom));
      else if (r < 5) add_frame(1'b1, $urandom, $urandom);
      else            add_frame(1'b0, $urandom, $urandom);
    end
    drain(20000);
    chk("all_txns_done", exp_txn.size(), 0);
    chk("all_tx_bytes_done", exp_tx.size(), 0);

    // Reset in the middle of ACCESS
    stall_pct = 0; txf_mode = 0; fix_wait = 1000;
    add_frame(1'b0, 32'h0000_6000, 32'h0);
    begin
      int n;
      n = 0;
      while (!(apb_pending && !apb_first) && n < 100) begin cycle(); n++; end
      chk("reach_access", n < 100, 1);
    end
    cycle();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_psel", psel, 1'b0);
    chk("rst_penable", penable, 1'b0);
    chk("rst_tx_wr_en", tx_wr_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    apb_pending = 0; apb_first = 0; mid_frame = 0; resp_pending = 0;
    exp_txn.delete(); exp_tx.delete();
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    base = got_tx.size();
    for (int i = 0; i < 10; i++) cycle();
    chk("post_reset_no_tx", got_tx.size() - base, 0);
    chk("post_reset_busy", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/uart2apb_frame_ctrl.md
# uart2apb_frame_ctrl

Command sequencer between the byte-wide UART RX/TX FIFOs and a 32-bit APB master port inside the uart2apb bridge. It pops command frames from the RX FIFO, assembles address and write data, and runs one APB transfer per frame. It then pushes a status byte, plus read data on reads, into the TX FIFO. It is the only reader of the RX FIFO and the only writer of the TX FIFO.

## Interface
- TIMEOUT_CYC, 100000, idle cycles allowed between bytes of one frame (timeout build only)
- TO_W, 17, timeout counter width; requires 2^TO_W > TIMEOUT_CYC
- clk  in  1  single system clock; both FIFOs are instantiated with FIFO_TYPE "SYNC_FIFO" on this clock
- rst_n  in  1  asynchronous, active-low reset
- rx_empty  in  1  RX FIFO empty
- rx_rd_data  in  8  RX FIFO head byte; the FIFO uses OUT_REG=0, so this is valid whenever rx_empty=0
- rx_rd_en  out  1  pops the head byte
- tx_full  in  1  TX FIFO full
- tx_wr_en  out  1  pushes tx_wr_data
- tx_wr_data  out  8  response byte
- paddr, pwdata  out  32  APB address, write data
- pwrite, psel, penable  out  1  APB control
- prdata  in  32  APB read data
- pready, pslverr  in  1  APB completion, slave error
- busy  out  1  high in every state except IDLE
- frame_err  out  1  one-cycle pulse when an illegal command byte is discarded
- timeout_err  out  1  one-cycle pulse when a frame is aborted by timeout

## Operation
- Frame format: command byte, then 4 address bytes, MSB first. A write frame adds 4 data bytes, MSB first.
- Command codes: 0x57 = write, 0x52 = read. Any other byte is popped and discarded, and frame_err pulses.
- Response for a write: one status byte. Response for a read: one status byte, then prdata as 4 bytes MSB first.
- Status byte: 0x00 = OK, 0x01 = pslverr. On a read with pslverr, the data bytes are still sent, carrying the captured prdata.
- FSM states and transitions:
  - IDLE: go to ADDR on a legal command byte.
  - ADDR: pop 4 bytes. On the 4th byte, go to WDATA (write) or SETUP (read).
  - WDATA: pop 4 bytes, then go to SETUP.
  - SETUP: psel=1, penable=0, for one cycle.
  - ACCESS: psel=1, penable=1, until pready=1. Capture prdata and pslverr in that cycle.
  - RESP: push the status byte, then the data bytes on a read. Return to IDLE.
- Byte consumption: rx_rd_en = ~rx_empty while in IDLE, ADDR or WDATA. Never assert it in any other state.
- Byte assembly: shift left by 8 and insert the new byte at [7:0]. The byte counter is 2 bits and wraps 3→0 at each field boundary.
- RESP pacing: tx_wr_en = ~tx_full. The byte index advances only on an accepted push. The FSM stalls indefinitely while the TX FIFO is full.
- paddr, pwdata and pwrite are held stable from SETUP until ACCESS completes.

## Timing
- Reset values: all outputs 0, FSM in IDLE, all internal registers 0.
- With back-to-back bytes available, one byte is popped per cycle. A write frame is popped in 9 cycles, a read frame in 5.
- Pop to APB: the cycle after the last frame byte is popped, the FSM is in SETUP. The ACCESS cycle follows.
- Read, pready on first ACCESS cycle, TX not full: status is pushed the following cycle and data in the next 4 cycles. Write: status only.
- pready is sampled only while psel and penable are both high.
- rst_n asserted mid-frame or mid-transfer: psel and penable drop immediately, because reset is asynchronous. No response byte is emitted. The partial frame is lost.
- No pipelining: the next frame is not popped until RESP completes.

## Configuration
- Macro: UART2APB_FRAME_TIMEOUT_EN
- Defined:
  - A counter clears on every pop and on entry to ADDR, and increments in ADDR and WDATA while rx_empty=1.
  - When the counter reaches TIMEOUT_CYC, the FSM returns to IDLE, timeout_err pulses for one cycle, and no APB transfer or response occurs.
  - SETUP, ACCESS and RESP are not timed.
- Undefined: no counter is built, timeout_err is tied to 0, and the FSM waits indefinitely for frame bytes.

## Structure
- Package uart2apb_pkg holds:
  - the FSM state enum (IDLE, ADDR, WDATA, SETUP, ACCESS, RESP);
  - CMD_WR = 8'h57, CMD_RD = 8'h52;
  - ST_OK = 8'h00, ST_SLVERR = 8'h01.
- One sub-module: uart2apb_timeout_cnt (counter plus compare, TIMEOUT_CYC and TO_W parameters). Instantiate it only under UART2APB_FRAME_TIMEOUT_EN.

## Test plan
- Write: RX holds 57 00 00 10 04 DE AD BE EF, pready high in the first ACCESS cycle → paddr=0x00001004, pwdata=0xDEADBEEF, pwrite=1; TX receives 00.
- Read with wait states: RX holds 52 00 00 20 00, pready low for 3 ACCESS cycles, prdata=0x12345678 → TX receives 00 12 34 56 78; penable is high for exactly 4 cycles.
- Slave error and backpressure: read with pslverr=1 and tx_full toggling every cycle → TX receives exactly 01 followed by the 4 data bytes, with no duplicates and no drops.
- Illegal byte: RX holds A5 then a valid read frame → frame_err pulses once, then the read completes normally.
- Timeout (macro defined, TIMEOUT_CYC=16): RX holds 57 00 then runs empty → timeout_err pulses 16 cycles after the last pop, with no APB activity. A following full frame completes normally.
- Reset mid-ACCESS: assert rst_n low → psel, penable and tx_wr_en are 0 asynchronously; after release, busy=0 and nothing is pushed to TX.
